// File: rtl/muldiv_seq.sv
// Iterative MIPS-style multiply/divide unit: one shift-add or restoring-divide step per cycle,
// with sign fix-up and the HI/LO write in a final cycle, and a stall output for the front of the pipeline.
module muldiv_seq #(
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            startE,
    input  logic            flushE,
    input  logic [1:0]      opE,
    input  logic [ITER-1:0] srcaE,
    input  logic [ITER-1:0] srcbE,
    input  logic            hireadD,
    input  logic            loreadD,
    output logic            stallMD,
    output logic            busy,
    output logic [ITER-1:0] hi,
    output logic [ITER-1:0] lo,
    output logic            done
);

    localparam int W  = ITER;
    localparam int CW = (ITER > 2) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FINISH
    } state_t;

    state_t          state_q,   state_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic            is_div_q,  is_div_d;
    logic [2*W-1:0]  work_q,    work_d;
    logic [W:0]      opnd_q,    opnd_d;
    logic [W-1:0]    a_raw_q,   a_raw_d;
    logic            neg_q,     neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic            div0_q,    div0_d;
    logic [W-1:0]    hi_q,      hi_d;
    logic [W-1:0]    lo_q,      lo_d;
    logic            done_q,    done_d;

    logic            accept;
    logic            sign_a, sign_b;
    logic [W:0]      ext_a, ext_b;
    logic [W:0]      mag_a, mag_b;

    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next;
    logic [W:0]      div_rem_sh;
    logic            div_ge;
    logic [W-1:0]    div_rem_new;
    logic [2*W-1:0]  div_next;

    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quot_mag, rem_mag;
    logic [W-1:0]    quot_fix, rem_fix;
    logic [W-1:0]    res_hi, res_lo;

    assign accept  = (state_q == S_IDLE) & startE & ~flushE;
    assign busy    = (state_q != S_IDLE);
    assign stallMD = busy & (hireadD | loreadD | startE);
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign done    = done_q;

    // Magnitudes are one bit wider so that 0x80000000 negates cleanly to 2^31.
    always_comb begin
        sign_a = ~opE[0] & srcaE[W-1];
        sign_b = ~opE[0] & srcbE[W-1];
        ext_a  = {sign_a, srcaE};
        ext_b  = {sign_b, srcbE};
        mag_a  = sign_a ? -ext_a : ext_a;
        mag_b  = sign_b ? -ext_b : ext_b;
    end

    // Multiply step: work holds {partial product, remaining multiplier bits}.
    always_comb begin
        mul_sum  = {1'b0, work_q[2*W-1:W]} + (work_q[0] ? opnd_q : '0);
        mul_next = {mul_sum, work_q[W-1:1]};
    end

    // Divide step: work holds {remainder, dividend bits becoming quotient bits}.
    always_comb begin
        div_rem_sh  = {work_q[2*W-1:W], work_q[W-1]};
        div_ge      = (div_rem_sh >= opnd_q);
        div_rem_new = W'(div_ge ? (div_rem_sh - opnd_q) : div_rem_sh);
        div_next    = {div_rem_new, work_q[W-2:0], div_ge};
    end

    always_comb begin
        prod_fix = neg_q ? -work_q : work_q;
        quot_mag = work_q[W-1:0];
        rem_mag  = work_q[2*W-1:W];
        quot_fix = neg_q ? -quot_mag : quot_mag;
        rem_fix  = rem_neg_q ? -rem_mag : rem_mag;
        if (!is_div_q) begin
            res_hi = prod_fix[2*W-1:W];
            res_lo = prod_fix[W-1:0];
        end else if (div0_q) begin
            res_hi = a_raw_q;
            res_lo = '1;
        end else begin
            res_hi = rem_fix;
            res_lo = quot_fix;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        work_d    = work_q;
        opnd_d    = opnd_q;
        a_raw_d   = a_raw_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_BUSY;
                    cnt_d     = '0;
                    is_div_d  = opE[1];
                    a_raw_d   = srcaE;
                    neg_d     = sign_a ^ sign_b;
                    rem_neg_d = sign_a;
                    div0_d    = opE[1] & (srcbE == '0);
                    if (opE[1]) begin
                        work_d = {{W{1'b0}}, mag_a[W-1:0]};
                        opnd_d = mag_b;
                    end else begin
                        work_d = {{W{1'b0}}, mag_b[W-1:0]};
                        opnd_d = mag_a;
                    end
                end
            end
            S_BUSY: begin
                cnt_d  = cnt_q + CW'(1);
                work_d = is_div_q ? div_next : mul_next;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                hi_d    = res_hi;
                lo_d    = res_lo;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            work_q    <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            work_q    <= work_d;
            opnd_q    <= opnd_d;
            a_raw_q   <= a_raw_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized and directed bench for muldiv_seq against a plain-arithmetic reference of HI/LO.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        startE, flushE;
    logic [1:0]  opE;
    logic [31:0] srcaE, srcbE;
    logic        hireadD, loreadD;
    logic        stallMD, busy, done;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    muldiv_seq #(.ITER(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .startE  (startE),
        .flushE  (flushE),
        .opE     (opE),
        .srcaE   (srcaE),
        .srcbE   (srcbE),
        .hireadD (hireadD),
        .loreadD (loreadD),
        .stallMD (stallMD),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {HI, LO} straight from the instruction-set meaning of each op.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00: p = sa * sb;
            2'b01: p = ua * ub;
            2'b10: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'h7FFF_FFFF;
            4: v = 32'($urandom_range(0, 20));
            5: v = -32'($urandom_range(1, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        opE    = op;
        srcaE  = a;
        srcbE  = b;
        startE = 1'b1;
        flushE = 1'b0;
        tick();
        startE = 1'b0;
    endtask

    task automatic wait_done(input logic [63:0] prev, input bit rnd_flush, output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            if (rnd_flush) flushE = 1'($urandom_range(0, 1));
            tick();
            n++;
            if (n == 16) check_eq("hold", {hi, lo}, prev);
        end
        flushE = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input bit rnd_flush);
        logic [63:0] prev;
        int n;
        prev = {hi, lo};
        start_op(op, a, b);
        wait_done(prev, rnd_flush, n);
        check_eq({tag, "_lat"}, 64'(n), 64'd33);
        check_eq(tag, {hi, lo}, exp);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        $display("[TB] %s op=%0d a=%h b=%h -> hi=%h lo=%h", tag, op, a, b, hi, lo);
        tick();
        check_eq({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] prev, exp1, exp2;
        int n, stall_bad, done_seen;
        logic [1:0] op;
        logic [31:0] a, b;

        reset = 1'b1; startE = 1'b0; flushE = 1'b0; opE = 2'b00;
        srcaE = '0; srcbE = '0; hireadD = 1'b0; loreadD = 1'b0;
        #8;
        check_eq("rst_hilo", {hi, lo}, 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_stall", 64'(stallMD), 64'd0);
        #4 reset = 1'b0;
        tick();

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
        run_op("mult_neg", 2'b00, -32'd3, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        run_op("div_neg", 2'b10, -32'd7, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_op("divu_zero", 2'b11, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF, 1'b0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
        run_op("div_zero_s", 2'b10, -32'd5, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF, 1'b0);
        run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);

        // Flushed start in IDLE must be ignored.
        prev = {hi, lo};
        opE = 2'b01; srcaE = 32'd9; srcbE = 32'd9; startE = 1'b1; flushE = 1'b1;
        tick();
        startE = 1'b0; flushE = 1'b0;
        check_eq("flush_busy", 64'(busy), 64'd0);
        tick();
        check_eq("flush_hilo", {hi, lo}, prev);
        check_eq("flush_done", 64'(done), 64'd0);

        // mflo waiting in Decode stalls for the whole operation, with flushes that must not abort it.
        start_op(2'b11, 32'd100, 32'd7);
        loreadD = 1'b1;
        stall_bad = 0; n = 0;
        while (done !== 1'b1 && n < 40) begin
            if (stallMD !== 1'b1) stall_bad++;
            flushE = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        flushE = 1'b0;
        check_eq("mflo_stall", 64'(stall_bad), 64'd0);
        check_eq("mflo_lat", 64'(n), 64'd33);
        check_eq("mflo_nostall", 64'(stallMD), 64'd0);
        check_eq("mflo_lo", 64'(lo), 64'd14);
        check_eq("mflo_hi", 64'(hi), 64'd2);
        loreadD = 1'b0;
        tick();

        // Back-to-back: second start held by the stall, accepted in the first IDLE cycle.
        exp1 = ref_model(2'b01, 32'd1234, 32'd5678);
        exp2 = ref_model(2'b11, 32'd1000, 32'd3);
        start_op(2'b01, 32'd1234, 32'd5678);
        opE = 2'b11; srcaE = 32'd1000; srcbE = 32'd3; startE = 1'b1;
        stall_bad = 0; n = 0;
        while (done !== 1'b1 && n < 40) begin
            if (stallMD !== 1'b1) stall_bad++;
            tick();
            n++;
        end
        check_eq("b2b_stall", 64'(stall_bad), 64'd0);
        check_eq("b2b_first", {hi, lo}, exp1);
        check_eq("b2b_idle_stall", 64'(stallMD), 64'd0);
        tick();
        startE = 1'b0;
        check_eq("b2b_accept", 64'(busy), 64'd1);
        wait_done(exp1, 1'b0, n);
        check_eq("b2b_lat", 64'(n), 64'd33);
        check_eq("b2b_second", {hi, lo}, exp2);
        tick();

        // Reset in the middle of an operation discards it immediately.
        start_op(2'b00, 32'd12345, 32'd678);
        loreadD = 1'b1;
        repeat (10) tick();
        #2 reset = 1'b1;
        #1;
        check_eq("rmid_hilo", {hi, lo}, 64'd0);
        check_eq("rmid_busy", 64'(busy), 64'd0);
        check_eq("rmid_stall", 64'(stallMD), 64'd0);
        #2 reset = 1'b0;
        loreadD = 1'b0;
        done_seen = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        check_eq("rmid_nodone", 64'(done_seen), 64'd0);
        check_eq("rmid_hold", {hi, lo}, 64'd0);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick_operand();
            b  = pick_operand();
            run_op("rand", op, a, b, ref_model(op, a, b), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have parameter ITER, default 32, meaning iteration cycles per operation, equal to the operand width.
REQ-002 Port clk, input, 1: rising-edge clock for all state.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port startE, input, 1: multiply/divide instruction present in Execute.
REQ-005 Port flushE, input, 1: Execute stage being flushed this cycle.
REQ-006 Port opE, input, 2: operation select; 00 mult, 01 multu, 10 div, 11 divu.
REQ-007 Port srcaE, input, 32: rs operand (multiplicand/dividend).
REQ-008 Port srcbE, input, 32: rt operand (multiplier/divisor).
REQ-009 Port hireadD, input, 1: mfhi in Decode.
REQ-010 Port loreadD, input, 1: mflo in Decode.
REQ-011 Port stallMD, output, 1: freeze Fetch, Decode and Execute.
REQ-012 Port busy, output, 1: operation in progress.
REQ-013 Port hi, output, 32: HI register.
REQ-014 Port lo, output, 32: LO register.
REQ-015 Port done, output, 1: one-cycle pulse marking the HI/LO update.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, BUSY and FINISH; busy SHALL equal (state != IDLE).
REQ-017 Acceptance SHALL occur when state=IDLE, startE=1 and flushE=0; the operation then moves to BUSY at that edge (E0), latching opE, the operands, and the operand signs; the 5-bit counter SHALL be cleared to 0.
REQ-018 startE with flushE=1 SHALL be ignored, leaving state, HI and LO unchanged.
REQ-019 Each BUSY cycle SHALL perform one iteration and increment the counter; the iteration with count=ITER-1 (edge E32) SHALL move the FSM to FINISH.
REQ-020 Multiply SHALL use shift-add on magnitudes with a 64-bit accumulator: add the multiplicand when the multiplier LSB=1, then shift right one bit.
REQ-021 Divide SHALL use restoring division on magnitudes: shift the remainder:quotient pair left, trial-subtract the divisor, and set the quotient bit to 1 if the result is non-negative, otherwise restore.
REQ-022 For signed ops (mult, div), operand magnitudes SHALL be two's-complement absolute values; 0x80000000 SHALL be treated as magnitude 2^31 using 33-bit internal width.
REQ-023 Sign correction SHALL occur in FINISH:
- mult: the product is negated if the operand signs differ.
- div: the quotient is negated if the signs differ; the remainder takes the sign of the dividend.
REQ-024 At the FINISH edge (E33), HI/LO SHALL be written and the FSM SHALL return to IDLE:
- mult/multu: HI = product[63:32], LO = product[31:0].
- div/divu: HI = remainder, LO = quotient.
REQ-025 done SHALL be 1 for exactly the cycle following E33.
REQ-026 Divide by zero SHALL produce HI = dividend (unmodified srcaE) and LO = 0xFFFFFFFF, with the same 33-edge latency.
REQ-027 Signed div of 0x80000000 by 0xFFFFFFFF SHALL produce LO = 0x80000000 and HI = 0.
REQ-028 HI and LO SHALL change only at E33 or on reset, and SHALL hold otherwise.
REQ-029 stallMD SHALL equal busy & (hireadD | loreadD | startE), and SHALL be combinational.
REQ-030 A startE arriving while busy SHALL not be accepted; it is held by the stall and accepted in the first IDLE cycle.
REQ-031 mfhi/mflo in the IDLE cycle after E33 SHALL see the new values, with no stall.
REQ-032 flushE while busy SHALL NOT abort the operation in progress.

Reset
REQ-033 Reset SHALL force state=IDLE, counter=0, hi=0, lo=0, done=0, busy=0 and stallMD=0 immediately, without waiting for a clock edge.
REQ-034 Reset asserted mid-operation SHALL discard the operation, and no HI/LO write SHALL follow deassertion.

Verification
REQ-035 The bench SHALL cover: multu 0xFFFFFFFF x 0xFFFFFFFF -> after 33 edges hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
REQ-036 The bench SHALL cover: mult -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-037 The bench SHALL cover: div -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7 / 0 -> hi=7, lo=0xFFFFFFFF.
REQ-038 The bench SHALL cover: mflo (loreadD=1) in Decode from cycle E0+1 -> stallMD=1 through the FINISH cycle, 0 in the cycle after E33, and lo holds the result.
REQ-039 The bench SHALL cover: back-to-back start -> second startE is stalled, accepted at the first IDLE cycle, and the first result is written before the second begins.
REQ-040 The bench SHALL cover: reset pulsed at iteration 10 -> hi=lo=0 immediately, busy=0, and no done pulse within 40 subsequent cycles.
